// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle LEGv8-subset processor:
// FSM state encoding, instruction classes, ALU operations and opcode fields.
package mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_RTYPE,
      CLS_LOAD,
      CLS_STORE,
      CLS_CBZ,
      CLS_B,
      CLS_MOVZ,
      CLS_ILLEGAL
   } cls_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_ORR,
      ALU_PASSB
   } alu_op_t;

   // Opcode fields, aligned to the top of the instruction word
   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
   localparam logic [5:0]  OPC_B    = 6'b000101;
   localparam logic [8:0]  OPC_MOVZ = 9'b110100101;

   // Classify an instruction from its top eleven bits (word bits 31:21)
   function automatic cls_t decode_class(input logic [10:0] opc);
      cls_t c;
      if (opc == OPC_ADD || opc == OPC_SUB || opc == OPC_AND || opc == OPC_ORR)
         c = CLS_RTYPE;
      else if (opc == OPC_LDUR)
         c = CLS_LOAD;
      else if (opc == OPC_STUR)
         c = CLS_STORE;
      else if (opc[10:3] == OPC_CBZ)
         c = CLS_CBZ;
      else if (opc[10:5] == OPC_B)
         c = CLS_B;
      else if (opc[10:2] == OPC_MOVZ)
         c = CLS_MOVZ;
      else
         c = CLS_ILLEGAL;
      return c;
   endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Control sequencer: walks FETCH/DECODE/EXEC/MEM/WB/HALT, decodes the
// instruction class and ALU operation, and issues datapath strobes.
// Memory request/strobe and halted are registered alongside the state.
module mc_control_fsm
   import mc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] opc_bits,
   input  logic        dmem_ready,
   output state_t      state,
   output cls_t        cls,
   output alu_op_t     alu_op,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        halted,
   output logic        ir_load,
   output logic        opnd_load,
   output logic        exec_en,
   output logic        result_capture,
   output logic        load_capture,
   output logic        reg_write,
   output logic        pc_advance
);

   state_t state_q, state_d;
   logic   dmem_req_q, dmem_req_d;
   logic   dmem_we_q, dmem_we_d;
   logic   halted_q, halted_d;

   // Instruction class and ALU operation straight from the opcode field
   always_comb begin
      cls    = decode_class(opc_bits);
      alu_op = ALU_ADD;
      if (cls == CLS_RTYPE) begin
         case (opc_bits)
            OPC_SUB: alu_op = ALU_SUB;
            OPC_AND: alu_op = ALU_AND;
            OPC_ORR: alu_op = ALU_ORR;
            default: alu_op = ALU_ADD;
         endcase
      end else if (cls == CLS_MOVZ) begin
         alu_op = ALU_PASSB;
      end
   end

   // Next state; the memory request is raised entering MEM and dropped
   // on the cycle the memory reports ready
   always_comb begin
      state_d    = state_q;
      dmem_req_d = dmem_req_q;
      dmem_we_d  = dmem_we_q;
      halted_d   = halted_q;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            if (cls == CLS_ILLEGAL) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (cls)
               CLS_LOAD, CLS_STORE: begin
                  state_d    = S_MEM;
                  dmem_req_d = 1'b1;
                  dmem_we_d  = (cls == CLS_STORE);
               end
               CLS_CBZ, CLS_B: state_d = S_FETCH;
               default:        state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (dmem_ready) begin
               dmem_req_d = 1'b0;
               dmem_we_d  = 1'b0;
               state_d    = (cls == CLS_LOAD) ? S_WB : S_FETCH;
            end
         end
         S_WB:   state_d = S_FETCH;
         S_HALT: halted_d = 1'b1;
         default: state_d = S_FETCH;
      endcase
   end

   // Datapath strobes, suppressed during reset so an aborted instruction
   // never writes a register or moves the PC
   always_comb begin
      ir_load        = !reset && (state_q == S_FETCH);
      opnd_load      = !reset && (state_q == S_DECODE);
      exec_en        = !reset && (state_q == S_EXEC);
      result_capture = !reset && (state_q == S_EXEC) &&
                       (cls == CLS_RTYPE || cls == CLS_MOVZ);
      load_capture   = !reset && (state_q == S_MEM) && dmem_ready && (cls == CLS_LOAD);
      reg_write      = !reset && (state_q == S_WB);
      pc_advance     = !reset && (((state_q == S_EXEC) && (cls == CLS_CBZ || cls == CLS_B)) ||
                                  ((state_q == S_MEM) && dmem_ready && (cls == CLS_STORE)) ||
                                  (state_q == S_WB));
   end

   // State register with registered control outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         dmem_req_q <= 1'b0;
         dmem_we_q  <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         dmem_req_q <= dmem_req_d;
         dmem_we_q  <= dmem_we_d;
         halted_q   <= halted_d;
      end
   end

   assign state    = state_q;
   assign dmem_req = dmem_req_q;
   assign dmem_we  = dmem_we_q;
   assign halted   = halted_q;

endmodule

// File: rtl/multicycle_proc.sv
// Multicycle LEGv8-subset processor: ADD/SUB/AND/ORR, LDUR/STUR, CBZ, B, MOVZ.
// Datapath lives here; sequencing is in mc_control_fsm.
// Define MC_PERF_COUNTERS_EN to add saturating cycle_count/instr_retired outputs.
// NREG may be at most 32; register NREG-1 is the hard-wired zero register.
module multicycle_proc
   import mc_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int NREG = 32
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic [XLEN-1:0] startpc,
   output logic [XLEN-1:0] currentpc,
   input  logic [31:0]     imem_rdata,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_ready,
   output logic [XLEN-1:0] MemtoRegOut,
   output logic [2:0]      state,
   output logic            halted
`ifdef MC_PERF_COUNTERS_EN
   ,
   output logic [XLEN-1:0] cycle_count,
   output logic [XLEN-1:0] instr_retired
`endif
);

   localparam logic [4:0] ZR_IDX = 5'(NREG - 1);

   state_t  fsm_state;
   cls_t    cls;
   alu_op_t alu_op;
   logic    ir_load, opnd_load, exec_en, result_capture, load_capture, reg_write, pc_advance;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     ir_q, ir_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d;
   logic [XLEN-1:0] alu_q, alu_d;
   logic [XLEN-1:0] mtr_q, mtr_d;
   logic [XLEN-1:0] regs_q [0:31];

   logic [4:0]      ra1, ra2, wa;
   logic [XLEN-1:0] rd1, rd2, opb, alu_res, br_off;
   logic            taken;

   // Field bits 11:10 (D-type op2) carry no meaning for this subset
   logic unused_ok;
   assign unused_ok = &{1'b0, ir_q[11:10]};

   mc_control_fsm u_ctrl (
      .clk            (CLK),
      .reset          (reset),
      .opc_bits       (ir_q[31:21]),
      .dmem_ready     (dmem_ready),
      .state          (fsm_state),
      .cls            (cls),
      .alu_op         (alu_op),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .halted         (halted),
      .ir_load        (ir_load),
      .opnd_load      (opnd_load),
      .exec_en        (exec_en),
      .result_capture (result_capture),
      .load_capture   (load_capture),
      .reg_write      (reg_write),
      .pc_advance     (pc_advance)
   );

   // Register read ports; CBZ tests Rt, STUR stores Rt, the zero register reads 0
   always_comb begin
      ra1 = (cls == CLS_CBZ)   ? ir_q[4:0] : ir_q[9:5];
      ra2 = (cls == CLS_STORE) ? ir_q[4:0] : ir_q[20:16];
      wa  = ir_q[4:0];
      rd1 = '0;
      rd2 = '0;
      if (ra1 < ZR_IDX) rd1 = regs_q[ra1];
      if (ra2 < ZR_IDX) rd2 = regs_q[ra2];
   end

   // ALU: second operand is a register, the D-type offset or the MOVZ immediate
   always_comb begin
      case (cls)
         CLS_LOAD, CLS_STORE: opb = {{(XLEN-9){ir_q[20]}}, ir_q[20:12]};
         CLS_MOVZ:            opb = {{(XLEN-16){1'b0}}, ir_q[20:5]} << {ir_q[22:21], 4'b0000};
         default:             opb = b_q;
      endcase
      case (alu_op)
         ALU_SUB:   alu_res = a_q - opb;
         ALU_AND:   alu_res = a_q & opb;
         ALU_ORR:   alu_res = a_q | opb;
         ALU_PASSB: alu_res = opb;
         default:   alu_res = a_q + opb;
      endcase
   end

   // Branch target selection and next-value logic for all datapath registers
   always_comb begin
      taken  = (cls == CLS_B) || ((cls == CLS_CBZ) && (a_q == '0));
      br_off = (cls == CLS_B) ? {{(XLEN-28){ir_q[25]}}, ir_q[25:0], 2'b00}
                              : {{(XLEN-21){ir_q[23]}}, ir_q[23:5], 2'b00};
      pc_d  = pc_q;
      if (pc_advance) pc_d = pc_q + (taken ? br_off : XLEN'(4));
      ir_d  = ir_load ? imem_rdata : ir_q;
      a_d   = opnd_load ? rd1 : a_q;
      b_d   = opnd_load ? rd2 : b_q;
      alu_d = exec_en ? alu_res : alu_q;
      mtr_d = mtr_q;
      if (result_capture)    mtr_d = alu_res;
      else if (load_capture) mtr_d = dmem_rdata;
   end

   // Datapath registers; reset reloads the PC and clears the write-port value
   always_ff @(posedge CLK) begin
      if (reset) begin
         pc_q  <= startpc;
         ir_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         alu_q <= '0;
         mtr_q <= '0;
      end else begin
         pc_q  <= pc_d;
         ir_q  <= ir_d;
         a_q   <= a_d;
         b_q   <= b_d;
         alu_q <= alu_d;
         mtr_q <= mtr_d;
      end
   end

   // Register file has no reset so its contents survive a reset pulse
   always_ff @(posedge CLK) begin
      if (reg_write && (wa < ZR_IDX)) regs_q[wa] <= mtr_q;
   end

   assign currentpc   = pc_q;
   assign dmem_addr   = alu_q;
   assign dmem_wdata  = b_q;
   assign MemtoRegOut = mtr_q;
   assign state       = fsm_state;

`ifdef MC_PERF_COUNTERS_EN
   logic [XLEN-1:0] cycle_count_q, cycle_count_d;
   logic [XLEN-1:0] instr_retired_q, instr_retired_d;

   // Saturating counters; both stop advancing once the core has halted
   always_comb begin
      cycle_count_d   = cycle_count_q;
      instr_retired_d = instr_retired_q;
      if (fsm_state != S_HALT && cycle_count_q != '1)
         cycle_count_d = cycle_count_q + XLEN'(1);
      if (pc_advance && instr_retired_q != '1)
         instr_retired_d = instr_retired_q + XLEN'(1);
   end

   // Counter registers
   always_ff @(posedge CLK) begin
      if (reset) begin
         cycle_count_q   <= '0;
         instr_retired_q <= '0;
      end else begin
         cycle_count_q   <= cycle_count_d;
         instr_retired_q <= instr_retired_d;
      end
   end

   assign cycle_count   = cycle_count_q;
   assign instr_retired = instr_retired_q;
`endif

endmodule

// File: tb/tb_multicycle_proc.sv
// Directed testbench for multicycle_proc: reset, ALU ops, load/store with
// wait states, branches, illegal-opcode halt and reset during a memory wait.
// Expected values are hand-computed from the instruction encodings below.
module tb_multicycle_proc;

   logic        CLK;
   logic        reset;
   logic [63:0] startpc;
   logic [63:0] currentpc;
   logic [31:0] imem_rdata;
   logic        dmem_req, dmem_we;
   logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ready;
   logic [63:0] MemtoRegOut;
   logic [2:0]  state;
   logic        halted;
`ifdef MC_PERF_COUNTERS_EN
   logic [63:0] cycle_count, instr_retired;
`endif

   logic [31:0] imem [0:255];
   int          vectorCount = 0;
   int          missCount = 0;
   int          waitCycles = 0;
   int          memCycle = 0;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   multicycle_proc dut (
      .CLK         (CLK),
      .reset       (reset),
      .startpc     (startpc),
      .currentpc   (currentpc),
      .imem_rdata  (imem_rdata),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_rdata  (dmem_rdata),
      .dmem_ready  (dmem_ready),
      .MemtoRegOut (MemtoRegOut),
      .state       (state),
      .halted      (halted)
`ifdef MC_PERF_COUNTERS_EN
      ,
      .cycle_count   (cycle_count),
      .instr_retired (instr_retired)
`endif
   );

   assign imem_rdata = imem[currentpc[9:2]];

   // Free-running clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Data memory responder: asserts ready after waitCycles stalled MEM cycles
   always @(negedge CLK) begin
      if (dmem_req) begin
         dmem_ready = (memCycle == waitCycles);
         memCycle   = memCycle + 1;
      end else begin
         dmem_ready = 1'b0;
         memCycle   = 0;
      end
   end

   function automatic logic [31:0] encR(input logic [10:0] opc, input int rd, input int rn, input int rm);
      return {opc, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
   endfunction

   function automatic logic [31:0] encD(input logic [10:0] opc, input int rt, input int rn, input int imm);
      return {opc, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
   endfunction

   function automatic logic [31:0] encB(input int off);
      return {6'b000101, 26'(off)};
   endfunction

   function automatic logic [31:0] encCbz(input int rt, input int off);
      return {8'b10110100, 19'(off), 5'(rt)};
   endfunction

   function automatic logic [31:0] encMovz(input int rd, input int imm);
      return {9'b110100101, 2'b00, 16'(imm), 5'(rd)};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge CLK);
      #1;
   endtask

   task automatic applyReset(input logic [63:0] pc);
      startpc = pc;
      reset   = 1'b1;
      @(posedge CLK);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      startpc    = 64'h0;
      dmem_rdata = 64'h0;
      dmem_ready = 1'b0;
      for (int i = 0; i < 256; i++) imem[i] = 32'h0;

      // Setup program at 0x000
      imem[0]  = encMovz(1, 5);
      imem[1]  = encMovz(2, 7);
      imem[2]  = encMovz(0, 0);
      imem[3]  = encMovz(5, 16'h55);
      imem[4]  = encMovz(4, 16'h40);
      imem[5]  = encMovz(31, 16'h77);
      // Main program at 0x100
      imem[64] = encR(11'b10001011000, 3, 1, 2);    // ADD X3,X1,X2
      imem[65] = encD(11'b11111000000, 3, 4, 8);    // STUR X3,[X4,#8]
      imem[66] = encR(11'b11001011000, 6, 2, 1);    // SUB X6,X2,X1
      imem[67] = encR(11'b10001010000, 7, 1, 2);    // AND X7,X1,X2
      imem[68] = encR(11'b10101010000, 8, 31, 4);   // ORR X8,XZR,X4
      imem[69] = encD(11'b11111000010, 9, 4, -8);   // LDUR X9,[X4,#-8]
      imem[70] = encB(58);                          // B 0x200
      imem[128] = encCbz(0, 2);                     // 0x200 CBZ X0,+2
      imem[130] = encMovz(0, 1);                    // 0x208 MOVZ X0,#1
      imem[131] = encB(-3);                         // 0x20C B 0x200
      // 0x204 stays 0: illegal
      imem[192] = encD(11'b11111000010, 5, 4, 0);   // 0x300 LDUR X5,[X4,#0]
      imem[193] = encD(11'b11111000000, 5, 4, 0);   // 0x304 STUR X5,[X4,#0]

      applyStimulus(2);
      applyReset(64'h100);
      checkOutput("reset pc", currentpc, 64'h100);
      checkOutput("reset state", 64'(state), 64'(ST_FETCH));
      checkOutput("reset req", 64'(dmem_req), 64'h0);
      checkOutput("reset we", 64'(dmem_we), 64'h0);
      checkOutput("reset halted", 64'(halted), 64'h0);
      checkOutput("reset mtr", MemtoRegOut, 64'h0);

      applyReset(64'h0);
      applyStimulus(24);
      checkOutput("setup pc", currentpc, 64'h18);
      checkOutput("movz xzr value", MemtoRegOut, 64'h77);

      applyReset(64'h100);
      applyStimulus(3);
      checkOutput("add wb state", 64'(state), 64'(ST_WB));
      checkOutput("add result", MemtoRegOut, 64'd12);
      checkOutput("add pc at 3", currentpc, 64'h100);
      applyStimulus(1);
      checkOutput("add pc at 4", currentpc, 64'h104);
      checkOutput("add back to fetch", 64'(state), 64'(ST_FETCH));

      waitCycles = 0;
      applyStimulus(3);
      checkOutput("stur state", 64'(state), 64'(ST_MEM));
      checkOutput("stur req", 64'(dmem_req), 64'h1);
      checkOutput("stur we", 64'(dmem_we), 64'h1);
      checkOutput("stur addr", dmem_addr, 64'h48);
      checkOutput("stur data", dmem_wdata, 64'd12);
      applyStimulus(1);
      checkOutput("stur pc", currentpc, 64'h108);
      checkOutput("stur req drop", 64'(dmem_req), 64'h0);

      applyStimulus(3);
      checkOutput("sub result", MemtoRegOut, 64'd2);
      applyStimulus(4);
      checkOutput("and result", MemtoRegOut, 64'd5);
      applyStimulus(4);
      checkOutput("orr xzr result", MemtoRegOut, 64'h40);
      applyStimulus(1);
      checkOutput("orr pc", currentpc, 64'h114);

      waitCycles = 3;
      dmem_rdata = 64'hDEAD;
      applyStimulus(3);
      checkOutput("ldur mem state", 64'(state), 64'(ST_MEM));
      checkOutput("ldur addr", dmem_addr, 64'h38);
      checkOutput("ldur we", 64'(dmem_we), 64'h0);
      applyStimulus(3);
      checkOutput("ldur still mem", 64'(state), 64'(ST_MEM));
      checkOutput("ldur req held", 64'(dmem_req), 64'h1);
      checkOutput("ldur addr held", dmem_addr, 64'h38);
      applyStimulus(1);
      checkOutput("ldur wb state", 64'(state), 64'(ST_WB));
      checkOutput("ldur data", MemtoRegOut, 64'hDEAD);
      applyStimulus(1);
      checkOutput("ldur pc", currentpc, 64'h118);

      applyStimulus(3);
      checkOutput("b fwd pc", currentpc, 64'h200);
      applyStimulus(3);
      checkOutput("cbz taken pc", currentpc, 64'h208);
      applyStimulus(4);
      checkOutput("movz x0 pc", currentpc, 64'h20C);
      applyStimulus(3);
      checkOutput("b back pc", currentpc, 64'h200);
      applyStimulus(2);
      checkOutput("cbz not taken pc at 2", currentpc, 64'h200);
      applyStimulus(1);
      checkOutput("cbz not taken pc", currentpc, 64'h204);

      applyStimulus(2);
      checkOutput("illegal halted", 64'(halted), 64'h1);
      checkOutput("illegal state", 64'(state), 64'(ST_HALT));
      applyStimulus(10);
      checkOutput("halt pc frozen", currentpc, 64'h204);
      checkOutput("halt still halted", 64'(halted), 64'h1);

      waitCycles = 100;
      applyReset(64'h300);
      applyStimulus(5);
      checkOutput("abort in mem", 64'(state), 64'(ST_MEM));
      applyReset(64'h304);
      waitCycles = 0;
      checkOutput("abort state", 64'(state), 64'(ST_FETCH));
      checkOutput("abort req", 64'(dmem_req), 64'h0);
      checkOutput("abort pc", currentpc, 64'h304);
      applyStimulus(1);
      checkOutput("abort no new req", 64'(dmem_req), 64'h0);
      checkOutput("abort decode", 64'(state), 64'(ST_DECODE));
      applyStimulus(2);
      checkOutput("x5 unchanged", dmem_wdata, 64'h55);
      checkOutput("x5 store addr", dmem_addr, 64'h40);
      applyStimulus(1);
      checkOutput("final pc", currentpc, 64'h308);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
